grid_arbiter: RTL and testbench

- Shares the single-port grid RAM (64x32 cells, 3-bit) between three requesters: 0 = level loader, 1 = grid drawer, 2 = raytracer.
- Replaces the FSM-driven static access mux with a request/grant arbiter, so the engines may run concurrently.
- Sits in the main datapath between the engines and the grid instance.
- Round-robin fairness, one access per cycle, read-data return tagging.

---
 rtl/grid_arbiter.sv | 154 +++++++++++++++
 tb/tb_grid_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_arbiter.sv
// grid_arbiter: round-robin request/grant arbiter sharing the single-port
// grid RAM (64x32 cells, 3-bit) between three requesters
// (0 = level loader, 1 = grid drawer, 2 = raytracer).
//
// Ports:
//   clock, reset             system clock, asynchronous active-high reset
//   rK_req/write/x/y/wdata   requester K access (K = 0..2), held until rK_gnt
//   rK_lock                  requester K lock request (GRID_ARB_LOCK_EN only)
//   rK_gnt                   combinational: access accepted on the next edge
//   rK_rvalid                read data for requester K is on rdata this cycle
//   rdata                    shared read-data bus (= grid_out)
//   grid_x/y/write/in        combinational mux of the granted requester
//   grid_out                 RAM read data, one cycle after the read access
//   busy                     any request high or any read return pending
//
// Build option: define GRID_ARB_LOCK_EN to add the owner lock, which lets one
// requester hold the RAM across several accesses.
module grid_arbiter #(
    parameter int unsigned X_W = 6,
    parameter int unsigned Y_W = 5,
    parameter int unsigned D_W = 3
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           r0_req,
    input  logic           r0_write,
    input  logic [X_W-1:0] r0_x,
    input  logic [Y_W-1:0] r0_y,
    input  logic [D_W-1:0] r0_wdata,
    input  logic           r0_lock,
    output logic           r0_gnt,
    output logic           r0_rvalid,
    input  logic           r1_req,
    input  logic           r1_write,
    input  logic [X_W-1:0] r1_x,
    input  logic [Y_W-1:0] r1_y,
    input  logic [D_W-1:0] r1_wdata,
    input  logic           r1_lock,
    output logic           r1_gnt,
    output logic           r1_rvalid,
    input  logic           r2_req,
    input  logic           r2_write,
    input  logic [X_W-1:0] r2_x,
    input  logic [Y_W-1:0] r2_y,
    input  logic [D_W-1:0] r2_wdata,
    input  logic           r2_lock,
    output logic           r2_gnt,
    output logic           r2_rvalid,
    output logic [D_W-1:0] rdata,
    output logic [X_W-1:0] grid_x,
    output logic [Y_W-1:0] grid_y,
    output logic           grid_write,
    output logic [D_W-1:0] grid_in,
    input  logic [D_W-1:0] grid_out,
    output logic           busy
);

    logic [2:0]            req_v;
    logic [2:0]            wr_v;
    logic [2:0][X_W-1:0]   x_v;
    logic [2:0][Y_W-1:0]   y_v;
    logic [2:0][D_W-1:0]   wd_v;
    logic [2:0]            elig;
    logic [1:0]            last;
    logic [2:0]            rv;
    logic [1:0]            gnt_idx;
    logic                  gnt_any;
    logic                  acc;
    logic [2:0]            gnt_v;

    assign req_v = {r2_req, r1_req, r0_req};
    assign wr_v  = {r2_write, r1_write, r0_write};
    assign x_v   = {r2_x, r1_x, r0_x};
    assign y_v   = {r2_y, r1_y, r0_y};
    assign wd_v  = {r2_wdata, r1_wdata, r0_wdata};

`ifdef GRID_ARB_LOCK_EN
    logic [2:0] lock_v;
    logic [1:0] owner;
    logic       owner_v;

    assign lock_v = {r2_lock, r1_lock, r0_lock};
    // While owned, only the owner may be granted; others stall.
    assign elig   = owner_v ? (req_v & 3'(3'b001 << owner)) : req_v;

    // Lock owner: taken by an accepted access with lock set, dropped by an
    // accepted owner access with lock clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner   <= 2'd0;
            owner_v <= 1'b0;
        end else if (acc) begin
            if (lock_v[gnt_idx]) begin
                owner   <= gnt_idx;
                owner_v <= 1'b1;
            end else begin
                owner_v <= 1'b0;
            end
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^{r0_lock, r1_lock, r2_lock};
    assign elig        = req_v;
`endif

    // Round-robin search starting just after the last accepted requester.
    always_comb begin
        logic [1:0] cand;
        gnt_idx = 2'd0;
        gnt_any = 1'b0;
        cand    = 2'd0;
        for (int unsigned i = 1; i <= 3; i++) begin
            cand = 2'((32'(last) + i) % 32'd3);
            if (!gnt_any && elig[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Grants drop immediately while reset is asserted.
    assign acc   = gnt_any && !reset;
    assign gnt_v = acc ? 3'(3'b001 << gnt_idx) : 3'b000;

    assign r0_gnt = gnt_v[0];
    assign r1_gnt = gnt_v[1];
    assign r2_gnt = gnt_v[2];

    assign grid_x     = acc ? x_v[gnt_idx]  : '0;
    assign grid_y     = acc ? y_v[gnt_idx]  : '0;
    assign grid_in    = acc ? wd_v[gnt_idx] : '0;
    assign grid_write = acc && wr_v[gnt_idx];

    // Arbitration pointer and read-return tag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last <= 2'd2;
            rv   <= 3'b000;
        end else begin
            rv <= (acc && !wr_v[gnt_idx]) ? gnt_v : 3'b000;
            if (acc) begin
                last <= gnt_idx;
            end
        end
    end

    assign r0_rvalid = rv[0];
    assign r1_rvalid = rv[1];
    assign r2_rvalid = rv[2];
    assign rdata     = grid_out;
    assign busy      = (|req_v) || (|rv);

endmodule

// File: tb/tb_grid_arbiter.sv
// Testbench for grid_arbiter: directed scenarios plus randomized traffic,
// checked against a behavioural arbiter/RAM model with a read-return
// scoreboard. Define GRID_ARB_LOCK_EN for both files to cover the lock.
module tb_grid_arbiter;
    localparam int unsigned X_W = 6;
    localparam int unsigned Y_W = 5;
    localparam int unsigned D_W = 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [2:0]     req, wr, lk;
    logic [X_W-1:0] xa [3];
    logic [Y_W-1:0] ya [3];
    logic [D_W-1:0] wd [3];
    logic [2:0]     gnt, rvalid;
    logic [D_W-1:0] rdata, grid_in, grid_out;
    logic [X_W-1:0] grid_x;
    logic [Y_W-1:0] grid_y;
    logic           grid_write, busy;

    grid_arbiter #(.X_W(X_W), .Y_W(Y_W), .D_W(D_W)) dut (
        .clock(clock), .reset(reset),
        .r0_req(req[0]), .r0_write(wr[0]), .r0_x(xa[0]), .r0_y(ya[0]),
        .r0_wdata(wd[0]), .r0_lock(lk[0]), .r0_gnt(gnt[0]), .r0_rvalid(rvalid[0]),
        .r1_req(req[1]), .r1_write(wr[1]), .r1_x(xa[1]), .r1_y(ya[1]),
        .r1_wdata(wd[1]), .r1_lock(lk[1]), .r1_gnt(gnt[1]), .r1_rvalid(rvalid[1]),
        .r2_req(req[2]), .r2_write(wr[2]), .r2_x(xa[2]), .r2_y(ya[2]),
        .r2_wdata(wd[2]), .r2_lock(lk[2]), .r2_gnt(gnt[2]), .r2_rvalid(rvalid[2]),
        .rdata(rdata), .grid_x(grid_x), .grid_y(grid_y), .grid_write(grid_write),
        .grid_in(grid_in), .grid_out(grid_out), .busy(busy)
    );

    // Grid RAM: single port, registered read.
    logic [D_W-1:0] ram [0:2047];
    always @(posedge clock) begin
        if (grid_write) ram[{grid_y, grid_x}] <= grid_in;
        grid_out <= ram[{grid_y, grid_x}];
    end

    // Reference model state.
    typedef struct {
        int             who;
        logic [D_W-1:0] data;
    } rd_t;

    logic [D_W-1:0] mem_ref [0:2047];
    rd_t rdq[$];
    int  m_last;
    bit  m_own_v;
    int  m_own;
    bit  m_rv_pend;
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string nm, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, want);
        end
    endtask

    task automatic model_reset();
        m_last    = 2;
        m_own_v   = 1'b0;
        m_own     = 0;
        m_rv_pend = 1'b0;
        rdq.delete();
    endtask

    // Winner: owner only while locked, else the first requester found
    // scanning forward (mod 3) from the one after the last winner.
    function automatic int model_pick();
        if (m_own_v) return req[m_own] ? m_own : -1;
        for (int i = 1; i <= 3; i++) begin
            int k;
            k = (m_last + i) % 3;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    task automatic set_req(input int k, input bit w, input int x, input int y,
                           input int d, input bit l);
        req[k] = 1'b1;
        wr[k]  = w;
        xa[k]  = X_W'(x);
        ya[k]  = Y_W'(y);
        wd[k]  = D_W'(d);
        lk[k]  = l;
    endtask

    // Called just after the falling edge with inputs set; checks the
    // combinational outputs, then advances the model by one accepted access.
    // exp_w >= 0 / -1 adds a directed grant check; -2 skips it.
    task automatic step(input int exp_w, output int w);
        int a;
        #1;
        w = model_pick();
        chk("gnt", int'(gnt), (w < 0) ? 0 : (1 << w));
        if (exp_w != -2) chk("gnt_directed", int'(gnt), (exp_w < 0) ? 0 : (1 << exp_w));
        chk("grid_write", int'(grid_write), (w < 0) ? 0 : int'(wr[w]));
        chk("grid_addr", int'({grid_y, grid_x}), (w < 0) ? 0 : int'({ya[w], xa[w]}));
        chk("grid_in", int'(grid_in), (w < 0) ? 0 : int'(wd[w]));
        chk("busy", int'(busy), int'((req != 3'b000) || m_rv_pend));
        m_rv_pend = 1'b0;
        if (w >= 0) begin
            a = int'({ya[w], xa[w]});
            if (wr[w]) begin
                mem_ref[a] = wd[w];
            end else begin
                rdq.push_back('{w, mem_ref[a]});
                m_rv_pend = 1'b1;
            end
            m_last = w;
`ifdef GRID_ARB_LOCK_EN
            if (lk[w]) begin
                m_own   = w;
                m_own_v = 1'b1;
            end else begin
                m_own_v = 1'b0;
            end
`endif
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 3'b000;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        int w;
        req = 3'b000;
        for (int i = 0; i < n; i++) begin
            step(-1, w);
            @(negedge clock);
        end
    endtask

    // Read-return monitor: every rvalid must match the oldest expected read.
    initial begin
        rd_t e;
        forever begin
            @(posedge clock);
            #1;
            if (rvalid != 3'b000 || rdq.size() != 0) begin
                if (rdq.size() == 0) begin
                    chk("rvalid_spurious", int'(rvalid), 0);
                end else begin
                    e = rdq.pop_front();
                    chk("rvalid_who", int'(rvalid), 1 << e.who);
                    if (rvalid != 3'b000) chk("rdata", int'(rdata), int'(e.data));
                end
            end
        end
    end

    initial begin
        int w;
        int n;
        int ord_rr [4];
        int ord_lk [6];

        for (int i = 0; i < 2048; i++) begin
            ram[i]     = '0;
            mem_ref[i] = '0;
        end
        reset = 1'b1;
        req = 3'b000; wr = 3'b000; lk = 3'b000;
        for (int k = 0; k < 3; k++) begin
            xa[k] = '0; ya[k] = '0; wd[k] = '0;
        end
        model_reset();

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        chk("reset_gnt", int'(gnt), 0);
        chk("reset_rvalid", int'(rvalid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_grid", int'({grid_y, grid_x, grid_write}), 0);
        @(negedge clock);
        reset = 1'b0;

        // Reset priority: all three read continuously
        ord_rr = '{0, 1, 2, 0};
        for (int k = 0; k < 3; k++) set_req(k, 1'b0, k + 1, k, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(ord_rr[i], w);
            @(negedge clock);
            if (w >= 0) set_req(w, 1'b0, $urandom_range(63), $urandom_range(31), 0, 1'b0);
        end
        idle(2);

        // Write then read same cell
        set_req(0, 1'b1, 5, 3, 3'b110, 1'b0);
        step(0, w);
        @(negedge clock);
        req[0] = 1'b0;
        set_req(2, 1'b0, 5, 3, 0, 1'b0);
        step(2, w);
        @(negedge clock);
        idle(2);

        // Sole requester
        for (int i = 0; i < 10; i++) begin
            set_req(1, 1'b0, i, 0, 0, 1'b0);
            step(1, w);
            @(negedge clock);
        end
        idle(2);

        // Mid-read reset
        set_req(2, 1'b0, 7, 7, 0, 1'b0);
        step(2, w);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("midreset_gnt", int'(gnt), 0);
        chk("midreset_rvalid", int'(rvalid), 0);
        @(posedge clock);
        #1;
        chk("midreset_no_rvalid", int'(rvalid), 0);
        @(negedge clock);
        req = 3'b000;
        @(negedge clock);
        reset = 1'b0;
        set_req(0, 1'b0, 1, 1, 0, 1'b0);
        set_req(2, 1'b0, 2, 2, 0, 1'b0);
        step(0, w);
        @(negedge clock);
        req[0] = 1'b0;
        step(2, w);
        @(negedge clock);
        idle(2);

        // Lock: r0 writes with lock 1,1,1,0 against continuous r1/r2 reads
        do_reset();
`ifdef GRID_ARB_LOCK_EN
        ord_lk = '{0, 0, 0, 0, 1, 2};
`else
        ord_lk = '{0, 1, 2, 0, 1, 2};
`endif
        n = 0;
        set_req(0, 1'b1, 10, 4, 1, 1'b1);
        set_req(1, 1'b0, 10, 4, 0, 1'b0);
        set_req(2, 1'b0, 11, 4, 0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step((i < 6) ? ord_lk[i] : -2, w);
            @(negedge clock);
            if (w == 0) begin
                n++;
                if (n < 4) set_req(0, 1'b1, 10 + n, 4, n + 1, n < 3);
                else req[0] = 1'b0;
            end else if (w > 0) begin
                set_req(w, 1'b0, 10 + $urandom_range(3), 4, 0, 1'b0);
            end
        end
        chk("lock_writes_done", n, 4);
        idle(2);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            step(-2, w);
            @(negedge clock);
            for (int k = 0; k < 3; k++) begin
                if (req[k] && w == k) begin
                    if ($urandom_range(1) == 1)
                        set_req(k, 1'($urandom_range(1)), $urandom_range(7), $urandom_range(3),
                                $urandom_range(7), $urandom_range(3) == 0);
                    else
                        req[k] = 1'b0;
                end else if (!req[k] && $urandom_range(99) < 40) begin
                    set_req(k, 1'($urandom_range(1)), $urandom_range(7), $urandom_range(3),
                            $urandom_range(7), $urandom_range(3) == 0);
                end
            end
        end

        // Idle: grid port quiet, busy falls one cycle after last rvalid
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
